// File: rtl/e203_oitf_pkg.sv
// Shared types and helpers for the out-of-order-completion OITF.
// Holds the entry payload, the default sizing and the wrap-aware pointer increment.
package e203_oitf_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_RIDX_W = 5;
  localparam int DEF_PC_W   = 32;

  typedef struct packed {
    logic [DEF_RIDX_W-1:0] rdidx;
    logic                  rdwen;
    logic                  rdfpu;
    logic [DEF_PC_W-1:0]   pc;
  } oitf_entry_t;

  // ext is {wrap_flag, ptr}; counting modulo 2*depth toggles the flag on each wrap.
  function automatic int ptr_inc(input int ext, input int depth);
    return (ext + 1) % (2 * depth);
  endfunction

endpackage

// File: rtl/e203_oitf_dep_match.sv
// Compares one dispatch register operand against every live OITF destination.
// Raises match when any live entry writes the same register in the same file.
module e203_oitf_dep_match #(
  parameter int DEPTH  = 4,
  parameter int RIDX_W = 5
) (
  input  logic [DEPTH-1:0]        ent_live,
  input  logic [DEPTH-1:0]        ent_fpu,
  input  logic [DEPTH*RIDX_W-1:0] ent_idx,
  input  logic                    src_en,
  input  logic                    src_fpu,
  input  logic [RIDX_W-1:0]       src_idx,
  output logic                    match
);

  logic [DEPTH-1:0] hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign hit[gi] = ent_live[gi] & (ent_fpu[gi] == src_fpu) &
                     (ent_idx[gi*RIDX_W +: RIDX_W] == src_idx);
  end

  assign match = src_en & (|hit);

endmodule

// File: rtl/e203_exu_oitf_ooc.sv
// Outstanding-instruction track FIFO: in-order allocate, out-of-order completion,
// in-order retire of the completed head, dispatch hazard flags and full flush.
module e203_exu_oitf_ooc
  import e203_oitf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RIDX_W = DEF_RIDX_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  input  logic              dis_ena,
  output logic              dis_ready,
  output logic [PTR_W-1:0]  dis_ptr,
  input  logic              disp_i_rs1en,
  input  logic              disp_i_rs2en,
  input  logic              disp_i_rs3en,
  input  logic              disp_i_rs1fpu,
  input  logic              disp_i_rs2fpu,
  input  logic              disp_i_rs3fpu,
  input  logic [RIDX_W-1:0] disp_i_rs1idx,
  input  logic [RIDX_W-1:0] disp_i_rs2idx,
  input  logic [RIDX_W-1:0] disp_i_rs3idx,
  input  logic              disp_i_rdwen,
  input  logic              disp_i_rdfpu,
  input  logic [RIDX_W-1:0] disp_i_rdidx,
  input  logic [PC_W-1:0]   disp_i_pc,
  input  logic              cmp_ena,
  input  logic [PTR_W-1:0]  cmp_ptr,
  output logic              ret_valid,
  input  logic              ret_ready,
  output logic [PTR_W-1:0]  ret_ptr,
  output logic [RIDX_W-1:0] ret_rdidx,
  output logic              ret_rdwen,
  output logic              ret_rdfpu,
  output logic [PC_W-1:0]   ret_pc,
  output logic              oitfrd_match_disprs1,
  output logic              oitfrd_match_disprs2,
  output logic              oitfrd_match_disprs3,
  output logic              oitfrd_match_disprd,
  output logic              oitf_empty,
  output logic [PTR_W:0]    oitf_cnt
);

  logic [DEPTH-1:0] valid_reg, done_reg;
  oitf_entry_t      ent_reg [DEPTH];
  logic [PTR_W:0]   alloc_reg, head_reg;
  logic [PTR_W:0]   alloc_next, head_next;
  logic [PTR_W-1:0] alloc_idx, head_idx;
  logic             full, dis_fire, ret_fire;

  assign alloc_idx  = alloc_reg[PTR_W-1:0];
  assign head_idx   = head_reg[PTR_W-1:0];
  assign alloc_next = (PTR_W+1)'(ptr_inc(int'(alloc_reg), DEPTH));
  assign head_next  = (PTR_W+1)'(ptr_inc(int'(head_reg), DEPTH));

  assign full       = (alloc_idx == head_idx) & (alloc_reg[PTR_W] != head_reg[PTR_W]);
  assign oitf_empty = (alloc_reg == head_reg);
  assign oitf_cnt   = alloc_reg - head_reg;
  assign dis_ready  = ~full;
  assign dis_ptr    = alloc_idx;
  assign ret_ptr    = head_idx;
  assign ret_valid  = valid_reg[head_idx] & done_reg[head_idx];
  assign dis_fire   = dis_ena & dis_ready;
  assign ret_fire   = ret_valid & ret_ready;

  assign ret_rdidx  = RIDX_W'(ent_reg[head_idx].rdidx);
  assign ret_rdwen  = ent_reg[head_idx].rdwen;
  assign ret_rdfpu  = ent_reg[head_idx].rdfpu;
  assign ret_pc     = PC_W'(ent_reg[head_idx].pc);

  // Dispatch, completion and retire touch distinct slots, so their bit updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      done_reg  <= '0;
      alloc_reg <= '0;
      head_reg  <= '0;
    end else if (flush_req) begin
      valid_reg <= '0;
      done_reg  <= '0;
      alloc_reg <= '0;
      head_reg  <= '0;
    end else begin
      if (cmp_ena && valid_reg[cmp_ptr]) begin
        done_reg[cmp_ptr] <= 1'b1;
      end
      if (dis_fire) begin
        valid_reg[alloc_idx] <= 1'b1;
        done_reg[alloc_idx]  <= 1'b0;
        alloc_reg            <= alloc_next;
      end
      if (ret_fire) begin
        valid_reg[head_idx] <= 1'b0;
        head_reg            <= head_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dis_fire && !flush_req) begin
      ent_reg[alloc_idx] <= '{rdidx: DEF_RIDX_W'(disp_i_rdidx), rdwen: disp_i_rdwen,
                              rdfpu: disp_i_rdfpu, pc: DEF_PC_W'(disp_i_pc)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_req && cmp_ena && dis_fire) begin
      assert (cmp_ptr != alloc_idx);
    end
  end

  logic [DEPTH-1:0]        ent_live, ent_fpu;
  logic [DEPTH*RIDX_W-1:0] ent_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign ent_live[gi] = valid_reg[gi] & ent_reg[gi].rdwen;
    assign ent_fpu[gi]  = ent_reg[gi].rdfpu;
    assign ent_idx[gi*RIDX_W +: RIDX_W] = RIDX_W'(ent_reg[gi].rdidx);
  end

  // Port order: rs1, rs2, rs3, rd.
  logic [3:0]             src_en, src_fpu, match;
  logic [3:0][RIDX_W-1:0] src_idx;

  assign src_en  = {disp_i_rdwen, disp_i_rs3en, disp_i_rs2en, disp_i_rs1en};
  assign src_fpu = {disp_i_rdfpu, disp_i_rs3fpu, disp_i_rs2fpu, disp_i_rs1fpu};
  assign src_idx = {disp_i_rdidx, disp_i_rs3idx, disp_i_rs2idx, disp_i_rs1idx};

  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    e203_oitf_dep_match #(.DEPTH(DEPTH), .RIDX_W(RIDX_W)) u_match (
      .ent_live (ent_live),
      .ent_fpu  (ent_fpu),
      .ent_idx  (ent_idx),
      .src_en   (src_en[gi]),
      .src_fpu  (src_fpu[gi]),
      .src_idx  (src_idx[gi]),
      .match    (match[gi])
    );
  end

  assign oitfrd_match_disprs1 = match[0];
  assign oitfrd_match_disprs2 = match[1];
  assign oitfrd_match_disprs3 = match[2];
  assign oitfrd_match_disprd  = match[3];

endmodule

// File: tb/tb_e203_exu_oitf_ooc.sv
// Directed and randomized checks of the OITF against a program-order queue model.
module tb_e203_exu_oitf_ooc;

  localparam int DEPTH = 4;
  localparam int RIDX_W = 5;
  localparam int PC_W = 32;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst_n, flush_req, dis_ena, dis_ready;
  logic [PTR_W-1:0] dis_ptr, cmp_ptr, ret_ptr;
  logic rs1en, rs2en, rs3en, rs1fpu, rs2fpu, rs3fpu;
  logic [RIDX_W-1:0] rs1idx, rs2idx, rs3idx, rdidx, ret_rdidx;
  logic rdwen, rdfpu, cmp_ena, ret_valid, ret_ready, ret_rdwen, ret_rdfpu;
  logic [PC_W-1:0] pc, ret_pc;
  logic m_rs1, m_rs2, m_rs3, m_rd, oitf_empty;
  logic [PTR_W:0] oitf_cnt;

  always #5 clk = ~clk;

  e203_exu_oitf_ooc dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .dis_ena(dis_ena),
    .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .disp_i_rs1en(rs1en), .disp_i_rs2en(rs2en), .disp_i_rs3en(rs3en),
    .disp_i_rs1fpu(rs1fpu), .disp_i_rs2fpu(rs2fpu), .disp_i_rs3fpu(rs3fpu),
    .disp_i_rs1idx(rs1idx), .disp_i_rs2idx(rs2idx), .disp_i_rs3idx(rs3idx),
    .disp_i_rdwen(rdwen), .disp_i_rdfpu(rdfpu), .disp_i_rdidx(rdidx), .disp_i_pc(pc),
    .cmp_ena(cmp_ena), .cmp_ptr(cmp_ptr),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_ptr(ret_ptr),
    .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
    .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
    .oitf_empty(oitf_empty), .oitf_cnt(oitf_cnt)
  );

  typedef struct {
    int slot;
    logic [RIDX_W-1:0] rd;
    logic wen;
    logic fpu;
    logic [PC_W-1:0] pc;
    logic done;
  } ment_t;

  ment_t q[$];
  int m_alloc = 0;
  int m_head = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_match(input logic en, input logic fpu, input logic [RIDX_W-1:0] idx);
    logic r = 1'b0;
    foreach (q[i]) if (en && q[i].wen && q[i].fpu == fpu && q[i].rd == idx) r = 1'b1;
    return r;
  endfunction

  task automatic check_model();
    logic rv;
    rv = (q.size() > 0) && q[0].done;
    chk("dis_ready", 32'(dis_ready), 32'(q.size() < DEPTH));
    chk("dis_ptr", 32'(dis_ptr), 32'(m_alloc));
    chk("ret_ptr", 32'(ret_ptr), 32'(m_head));
    chk("ret_valid", 32'(ret_valid), 32'(rv));
    chk("oitf_empty", 32'(oitf_empty), 32'(q.size() == 0));
    chk("oitf_cnt", 32'(oitf_cnt), 32'(q.size()));
    chk("match_rs1", 32'(m_rs1), 32'(exp_match(rs1en, rs1fpu, rs1idx)));
    chk("match_rs2", 32'(m_rs2), 32'(exp_match(rs2en, rs2fpu, rs2idx)));
    chk("match_rs3", 32'(m_rs3), 32'(exp_match(rs3en, rs3fpu, rs3idx)));
    chk("match_rd", 32'(m_rd), 32'(exp_match(rdwen, rdfpu, rdidx)));
    if (rv) begin
      chk("ret_rdidx", 32'(ret_rdidx), 32'(q[0].rd));
      chk("ret_rdwen", 32'(ret_rdwen), 32'(q[0].wen));
      chk("ret_rdfpu", 32'(ret_rdfpu), 32'(q[0].fpu));
      chk("ret_pc", ret_pc, q[0].pc);
    end
  endtask

  task automatic model_edge();
    logic dis_f, ret_f;
    if (flush_req) begin
      q.delete();
      m_alloc = 0;
      m_head = 0;
      return;
    end
    dis_f = dis_ena && (q.size() < DEPTH);
    ret_f = ret_ready && (q.size() > 0) && q[0].done;
    if (cmp_ena) foreach (q[i]) if (q[i].slot == int'(cmp_ptr)) q[i].done = 1'b1;
    if (ret_f) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (dis_f) begin
      q.push_back('{slot: m_alloc, rd: rdidx, wen: rdwen, fpu: rdfpu, pc: pc, done: 1'b0});
      m_alloc = (m_alloc + 1) % DEPTH;
    end
  endtask

  task automatic cycle();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    flush_req = 0; dis_ena = 0; cmp_ena = 0; cmp_ptr = '0; ret_ready = 0;
    rs1en = 0; rs2en = 0; rs3en = 0; rs1fpu = 0; rs2fpu = 0; rs3fpu = 0;
    rs1idx = '0; rs2idx = '0; rs3idx = '0; rdwen = 0; rdfpu = 0; rdidx = '0; pc = '0;
  endtask

  task automatic disp(input int rd, input logic fpu, input logic wen, input int unsigned p);
    dis_ena = 1; rdidx = RIDX_W'(rd); rdfpu = fpu; rdwen = wen; pc = p;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dis_ready"}, 32'(dis_ready), 32'd1);
    chk({tag, "_empty"}, 32'(oitf_empty), 32'd1);
    chk({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(oitf_cnt), 32'd0);
    chk({tag, "_ptrs"}, 32'({dis_ptr, ret_ptr}), 32'd0);
    chk({tag, "_matches"}, 32'({m_rs1, m_rs2, m_rs3, m_rd}), 32'd0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1;

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      disp(i + 1, 1'b0, 1'b1, 32'h1000 + i * 4);
      #1;
      chk("fill_dis_ptr", 32'(dis_ptr), 32'(i));
      cycle();
    end
    idle();
    #1;
    chk("full_dis_ready", 32'(dis_ready), 32'd0);
    chk("full_cnt", 32'(oitf_cnt), 32'd4);
    disp(5, 1'b0, 1'b1, 32'h2000);
    cycle();
    idle();
    #1;
    chk("overflow_cnt", 32'(oitf_cnt), 32'd4);
    chk("overflow_ret_ptr", 32'(ret_ptr), 32'd0);

    // Full table, head done: retire + rejected dispatch + completion together
    cmp_ena = 1; cmp_ptr = 2'd0;
    cycle();
    idle();
    ret_ready = 1; cmp_ena = 1; cmp_ptr = 2'd2;
    disp(9, 1'b1, 1'b1, 32'h3000);
    #1;
    chk("simul_dis_ready", 32'(dis_ready), 32'd0);
    chk("simul_ret_valid", 32'(ret_valid), 32'd1);
    cycle();
    idle();
    #1;
    chk("simul_cnt", 32'(oitf_cnt), 32'd3);
    chk("simul_ret_valid_next", 32'(ret_valid), 32'd0);
    disp(9, 1'b1, 1'b1, 32'h3000);
    #1;
    chk("wrap_dis_ptr", 32'(dis_ptr), 32'd0);
    cycle();
    idle();
    #1;
    chk("wrap_cnt", 32'(oitf_cnt), 32'd4);
    cmp_ena = 1; cmp_ptr = 2'd1;
    cycle();
    idle();
    ret_ready = 1;
    cycle();
    idle();
    #1;
    chk("cmp_recorded_valid", 32'(ret_valid), 32'd1);
    chk("cmp_recorded_ptr", 32'(ret_ptr), 32'd2);

    // Flush with 3 live entries, dispatch and retire in the same cycle
    flush_req = 1; ret_ready = 1;
    disp(11, 1'b0, 1'b1, 32'h4000);
    cycle();
    idle();
    #1;
    chk("flush_empty", 32'(oitf_empty), 32'd1);
    chk("flush_cnt", 32'(oitf_cnt), 32'd0);
    chk("flush_ptrs", 32'({dis_ptr, ret_ptr}), 32'd0);

    // Out-of-order completion and hazard flags
    disp(3, 1'b0, 1'b1, 32'h5000);
    #1;
    chk("post_flush_dis_ptr", 32'(dis_ptr), 32'd0);
    cycle();
    idle(); disp(7, 1'b0, 1'b1, 32'h5004); cycle();
    idle(); disp(8, 1'b1, 1'b1, 32'h5008); cycle();
    idle();
    rs1en = 1; rs1fpu = 0; rs1idx = 5'd3;
    #1; chk("haz_rs1", 32'(m_rs1), 32'd1);
    rs1fpu = 1;
    #1; chk("haz_rs1_fpu", 32'(m_rs1), 32'd0);
    rs1fpu = 0; rs1en = 0;
    #1; chk("haz_rs1_en", 32'(m_rs1), 32'd0);
    rs1en = 1; rdwen = 1; rdfpu = 0; rdidx = 5'd3;
    #1; chk("haz_rd", 32'(m_rd), 32'd1);
    rdwen = 0;
    cmp_ena = 1; cmp_ptr = 2'd2;
    cycle();
    #1; chk("ooo_cmp2", 32'(ret_valid), 32'd0);
    cmp_ptr = 2'd1;
    cycle();
    #1; chk("ooo_cmp1", 32'(ret_valid), 32'd0);
    cmp_ptr = 2'd0;
    cycle();
    cmp_ena = 0;
    #1;
    chk("ooo_cmp0_valid", 32'(ret_valid), 32'd1);
    chk("ooo_cmp0_ptr", 32'(ret_ptr), 32'd0);
    chk("haz_after_done", 32'(m_rs1), 32'd1);
    ret_ready = 1;
    cycle();
    #1;
    chk("haz_after_retire", 32'(m_rs1), 32'd0);
    chk("retire_ptr1", 32'(ret_ptr), 32'd1);
    cycle();
    cycle();
    #1;
    chk("ooo_drained", 32'(oitf_empty), 32'd1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      idle();
      flush_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0)
        disp(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom);
      rdidx = RIDX_W'($urandom_range(0, 3));
      rs1en = 1'($urandom_range(0, 1)); rs1fpu = 1'($urandom_range(0, 1));
      rs2en = 1'($urandom_range(0, 1)); rs2fpu = 1'($urandom_range(0, 1));
      rs3en = 1'($urandom_range(0, 1)); rs3fpu = 1'($urandom_range(0, 1));
      rs1idx = RIDX_W'($urandom_range(0, 3));
      rs2idx = RIDX_W'($urandom_range(0, 3));
      rs3idx = RIDX_W'($urandom_range(0, 3));
      cmp_ena = 1'($urandom_range(0, 1));
      cmp_ptr = PTR_W'($urandom_range(0, DEPTH - 1));
      if (dis_ena && q.size() < DEPTH && int'(cmp_ptr) == m_alloc) cmp_ena = 0;
      ret_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Asynchronous reset in the middle of activity
    idle();
    disp(2, 1'b0, 1'b1, 32'h6000); cycle();
    idle(); disp(4, 1'b0, 1'b1, 32'h6004); cycle();
    idle();
    cmp_ena = 1; cmp_ptr = PTR_W'(q[0].slot); ret_ready = 1;
    rs1en = 1; rs1idx = 5'd2; rdwen = 1; rdidx = 5'd4;
    disp(4, 1'b0, 1'b1, 32'h6008);
    rdidx = 5'd4;
    #2;
    rst_n = 0;
    #1;
    chk_reset_state("midreset");
    q.delete();
    m_alloc = 0;
    m_head = 0;
    @(negedge clk);
    idle();
    rst_n = 1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
